// File: rtl/riscv_pkg.sv
// Shared core definitions for the fetch stage: datapath width, default reset PC,
// fetch FSM encoding and the sequential PC increment.
// The optional performance counters are enabled with FETCH_PERF_EN.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int PCPLUS4 = 4;

  // IDLE: one cycle after reset, REQ: request raised or about to be raised,
  // WAIT: one request accepted and its response not yet taken.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf.sv
// Saturating performance counters for the fetch stage: captured instructions,
// discarded wrong-path responses and decode stall cycles.
// Compiled only when FETCH_PERF_EN is defined; otherwise this file is empty.
`ifdef FETCH_PERF_EN
module fetch_perf #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_capture,
  input  logic            i_discard,
  input  logic            i_stall,
  output logic [XLEN-1:0] o_perf_fetched,
  output logic [XLEN-1:0] o_perf_dropped,
  output logic [XLEN-1:0] o_perf_stall
);

  logic [XLEN-1:0] r_fetched;
  logic [XLEN-1:0] r_dropped;
  logic [XLEN-1:0] r_stall;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Count each event once per cycle, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetched <= '0;
      r_dropped <= '0;
      r_stall   <= '0;
    end else begin
      if (i_capture) r_fetched <= sat_inc(r_fetched);
      if (i_discard) r_dropped <= sat_inc(r_dropped);
      if (i_stall)   r_stall   <= sat_inc(r_stall);
    end
  end

  assign o_perf_fetched = r_fetched;
  assign o_perf_dropped = r_dropped;
  assign o_perf_stall   = r_stall;

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request
// at a time and hands the fetched word to decode over a valid/ready handshake.
// A decode-side redirect retargets fetch; a response already in flight for the
// old path is taken and thrown away.
// Defining FETCH_PERF_EN adds the perf_fetched/perf_dropped/perf_stall counters.
module fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            imem_rready,
  output logic            instr_valid,
  input  logic            decode_ready,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_dropped,
  output logic [XLEN-1:0] perf_stall
`endif
);

  import riscv_pkg::*;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic            r_drop;
  logic            w_drop_nxt;
  logic            r_req;
  logic [XLEN-1:0] r_req_addr;
  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pcplus4;

  logic            w_consume;
  logic            w_redirect;
  logic            w_rready;
  logic            w_take;
  logic            w_discard;
  logic            w_capture;
  logic            w_accept;
  logic            w_raise;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_inc;

  assign w_consume  = r_valid & decode_ready;
  assign w_redirect = w_consume & PCSrc;
  // Only WAIT has a response outstanding, so acceptance is confined to it.
  assign w_rready   = (r_state == WAIT) & (r_drop | ~r_valid | w_consume);
  assign w_take     = imem_rvalid & w_rready;
  assign w_discard  = w_take & (r_drop | w_redirect);
  assign w_capture  = w_take & ~w_discard;
  assign w_accept   = r_req & imem_ready;
  // The request is raised one cycle after entering REQ (IDLE plays that role
  // after reset), so a redirect arriving with the just-captured instruction
  // retargets the next fetch without creating a wrong-path request.
  assign w_raise    = (r_state == IDLE) | ((r_state == REQ) & ~r_req);
  assign w_target   = PCTarget & ~XLEN'(3);
  assign w_pc_inc   = r_fetch_pc + XLEN'(PCPLUS4);

  // Next fetch PC: sequential advance on capture, redirect overrides it.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    w_fetch_pc_nxt = r_fetch_pc;
    if (w_capture)  w_fetch_pc_nxt = w_pc_inc;
    if (w_redirect) w_fetch_pc_nxt = w_target;
  end

  // FSM next state and wrong-path drop flag.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    case (r_state)
      IDLE:    w_state_nxt = REQ;
      REQ:     if (w_accept) w_state_nxt = WAIT;
      WAIT:    if (w_take)   w_state_nxt = REQ;
      default: w_state_nxt = IDLE;
    endcase
    if (w_take) w_drop_nxt = 1'b0;
    // A redirect while a request is raised or outstanding (and not resolved
    // this cycle) leaves a wrong-path response to discard later.
    if (w_redirect && (((r_state == WAIT) && !w_take) || ((r_state == REQ) && r_req)))
      w_drop_nxt = 1'b1;
  end

  // State, PC and drop registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  // Address channel: request and address held stable until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req      <= 1'b0;
      r_req_addr <= RESET_PC;
    end else if (w_raise) begin
      r_req      <= 1'b1;
      r_req_addr <= w_fetch_pc_nxt;
    end else if (w_accept) begin
      r_req      <= 1'b0;
    end
  end

  // Decode-side instruction register; a capture wins over a same-cycle consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_pc      <= '0;
      r_pcplus4 <= '0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_instr   <= imem_rdata;
      r_pc      <= r_fetch_pc;
      r_pcplus4 <= w_pc_inc;
    end else if (w_consume) begin
      r_valid   <= 1'b0;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_req_addr;
  assign imem_rready = w_rready;
  assign instr_valid = r_valid;
  assign Instr       = r_instr;
  assign PC          = r_pc;
  assign PCPlus4     = r_pcplus4;

`ifdef FETCH_PERF_EN
  fetch_perf #(.XLEN(XLEN)) u_perf (
    .clk            (clk),
    .reset          (reset),
    .i_capture      (w_capture),
    .i_discard      (w_discard),
    .i_stall        (r_valid & ~decode_ready),
    .o_perf_fetched (perf_fetched),
    .o_perf_dropped (perf_dropped),
    .o_perf_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, decode backpressure,
// redirects with and without an outstanding request, asynchronous reset in
// WAIT, and PC wrap-around on a second instance.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_rready;
  logic        instr_valid;
  logic        decode_ready;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_rready;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pcplus4;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
  logic [31:0] w_perf_fetched, w_perf_dropped, w_perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk          (clk),
    .reset        (reset),
    .PCSrc        (PCSrc),
    .PCTarget     (PCTarget),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .imem_rready  (imem_rready),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .Instr        (Instr),
    .PC           (PC),
    .PCPlus4      (PCPlus4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped),
    .perf_stall   (perf_stall)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk          (clk),
    .reset        (reset),
    .PCSrc        (1'b0),
    .PCTarget     (32'h0),
    .imem_req     (w_imem_req),
    .imem_addr    (w_imem_addr),
    .imem_ready   (1'b1),
    .imem_rvalid  (w_rvalid),
    .imem_rdata   (w_rdata),
    .imem_rready  (w_rready),
    .instr_valid  (w_valid),
    .decode_ready (1'b0),
    .Instr        (w_instr),
    .PC           (w_pc),
    .PCPlus4      (w_pcplus4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (w_perf_fetched),
    .perf_dropped (w_perf_dropped),
    .perf_stall   (w_perf_stall)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // Instruction memory model: one outstanding request, response m_lat cycles
  // after acceptance, held until taken.
  int          m_lat = 1;
  logic        m_pend = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_cnt = 0;
  int          cyc = 0;
  int          takes = 0;
  int          accepts = 0;
  logic [31:0] last_acc = '0;
  logic [31:0] acc_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_mem();
    imem_rvalid = m_pend && (m_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(m_addr) : 32'h0;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step();
    logic acc, tk;
    logic [31:0] a;
    drive_mem();
    #1;
    acc = imem_req & imem_ready;
    tk  = imem_rvalid & imem_rready;
    a   = imem_addr;
    @(posedge clk);
    cyc++;
    if (tk) begin
      m_pend = 1'b0;
      takes++;
    end else if (m_pend && m_cnt > 0) begin
      m_cnt--;
    end
    if (acc) begin
      m_pend   = 1'b1;
      m_addr   = a;
      m_cnt    = m_lat - 1;
      accepts++;
      last_acc = a;
      acc_log.push_back(a);
    end
    @(negedge clk);
    drive_mem();
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    PCSrc        = 1'b0;
    PCTarget     = 32'h0;
    decode_ready = 1'b0;
    imem_ready   = 1'b1;
    w_rvalid     = 1'b0;
    w_rdata      = 32'h0;
    m_pend       = 1'b0;
    m_cnt        = 0;
    acc_log.delete();
    drive_mem();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    #1;
  endtask

  // Wait for the next consume, report what decode saw, then let it happen.
  task automatic next_delivery(output logic [31:0] pc, output logic [31:0] ins,
                               output logic [31:0] p4, output int at_cyc);
    int n = 0;
    #1;
    while (!(instr_valid && decode_ready) && n < 100) begin
      step();
      #1;
      n++;
    end
    check("delivery_in_time", 32'(n < 100), 32'd1);
    pc     = PC;
    ins    = Instr;
    p4     = PCPlus4;
    at_cyc = cyc;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc, ins, p4;
    int c_a, c_b, t0, a0, n;

    // ---------------- sequential fetch ----------------
    apply_reset();
    check("rst_imem_req",    32'(imem_req),    32'd0);
    check("rst_imem_addr",   imem_addr,        32'h0);
    check("rst_imem_rready", 32'(imem_rready), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr",       Instr,            32'h0);
    check("rst_pc",          PC,               32'h0);
    check("rst_pcplus4",     PCPlus4,          32'h0);
    m_lat = 1;
    decode_ready = 1'b1;
    release_reset();
    next_delivery(pc, ins, p4, c_a);
    check("seq0_pc", pc, 32'h0000_0000);
    check("seq0_instr", ins, 32'h1357_9BDF);
    check("seq0_pcplus4", p4, 32'h0000_0004);
    next_delivery(pc, ins, p4, c_a);
    check("seq1_pc", pc, 32'h0000_0004);
    check("seq1_instr", ins, 32'h1357_9BDB);
    check("seq1_pcplus4", p4, 32'h0000_0008);
    next_delivery(pc, ins, p4, c_b);
    check("seq2_pc", pc, 32'h0000_0008);
    check("seq2_instr", ins, 32'h1357_9BD7);
    check("seq2_pcplus4", p4, 32'h0000_000C);
    check("seq_throughput", 32'(c_b - c_a), 32'd3);
    check("seq_req_count", 32'(acc_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3) begin
      check("seq_req0", acc_log[0], 32'h0);
      check("seq_req1", acc_log[1], 32'h4);
      check("seq_req2", acc_log[2], 32'h8);
    end

    // ---------------- decode backpressure ----------------
    apply_reset();
    m_lat = 1;
    release_reset();
    n = 0;
    while (!(instr_valid && imem_rvalid) && n < 50) begin
      step();
      #1;
      n++;
    end
    check("bp_reach_stall", 32'(n < 50), 32'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rready_low", 32'(imem_rready), 32'd0);
      check("bp_no_req", 32'(imem_req), 32'd0);
      check("bp_pc_held", PC, 32'h0);
      check("bp_instr_held", Instr, 32'h1357_9BDF);
      step();
    end
    decode_ready = 1'b1;
    #1;
    check("bp_release_rready", 32'(imem_rready), 32'd1);
    next_delivery(pc, ins, p4, c_a);
    check("bp_first_pc", pc, 32'h0);
    next_delivery(pc, ins, p4, c_a);
    check("bp_second_pc", pc, 32'h4);
    check("bp_second_instr", ins, 32'h1357_9BDB);

    // ---------------- redirect while idle ----------------
    apply_reset();
    m_lat = 1;
    decode_ready = 1'b1;
    release_reset();
    next_delivery(pc, ins, p4, c_a);
    next_delivery(pc, ins, p4, c_a);
    n = 0;
    while (!instr_valid && n < 50) begin
      step();
      #1;
      n++;
    end
    check("ri_pc8", PC, 32'h8);
    check("ri_no_req_pending", 32'(imem_req), 32'd0);
    PCSrc    = 1'b1;
    PCTarget = 32'h0000_0103;
    t0 = takes;
    step();
    PCSrc    = 1'b0;
    PCTarget = 32'h0;
    #1;
    check("ri_req", 32'(imem_req), 32'd1);
    check("ri_addr", imem_addr, 32'h0000_0100);
    next_delivery(pc, ins, p4, c_a);
    check("ri_pc", pc, 32'h0000_0100);
    check("ri_instr", ins, 32'h1357_9ADF);
    check("ri_pcplus4", p4, 32'h0000_0104);
    check("ri_no_discard", 32'(takes - t0), 32'd1);

    // ---------------- redirect with request outstanding ----------------
    apply_reset();
    m_lat = 4;
    decode_ready = 1'b1;
    release_reset();
    next_delivery(pc, ins, p4, c_a);
    next_delivery(pc, ins, p4, c_a);
    next_delivery(pc, ins, p4, c_a);
    n = 0;
    while (!instr_valid && n < 50) begin
      step();
      #1;
      n++;
    end
    decode_ready = 1'b0;
    check("ro_pc_c", PC, 32'hC);
    a0 = accepts;
    n = 0;
    while (accepts == a0 && n < 50) begin
      step();
      n++;
    end
    check("ro_outstanding_addr", last_acc, 32'h10);
    decode_ready = 1'b1;
    PCSrc    = 1'b1;
    PCTarget = 32'h0000_0200;
    t0 = takes;
    step();
    PCSrc    = 1'b0;
    PCTarget = 32'h0;
    #1;
    check("ro_consumed", 32'(instr_valid), 32'd0);
    next_delivery(pc, ins, p4, c_a);
    check("ro_pc", pc, 32'h0000_0200);
    check("ro_instr", ins, 32'h1357_99DF);
    check("ro_takes", 32'(takes - t0), 32'd2);

    // ---------------- asynchronous reset in WAIT ----------------
    apply_reset();
    m_lat = 4;
    release_reset();
    n = 0;
    while (accepts < a0 + 0 && n < 0) n++;
    a0 = accepts;
    n = 0;
    while (accepts < a0 + 2 && n < 50) begin
      step();
      n++;
    end
    check("ar_two_accepts", 32'(accepts - a0), 32'd2);
    check("ar_valid_before", 32'(instr_valid), 32'd1);
    #2;
    reset  = 1'b1;
    m_pend = 1'b0;
    drive_mem();
    #1;
    check("ar_valid_cleared", 32'(instr_valid), 32'd0);
    check("ar_req_cleared", 32'(imem_req), 32'd0);
    check("ar_pc_cleared", PC, 32'h0);
    check("ar_addr_reset", imem_addr, 32'h0);
    @(negedge clk);
    release_reset();
    check("ar_idle_no_req", 32'(imem_req), 32'd0);
    step();
    check("ar_first_req", 32'(imem_req), 32'd1);
    check("ar_first_addr", imem_addr, 32'h0);

    // ---------------- PC wrap-around ----------------
    apply_reset();
    release_reset();
    check("wr_idle_no_req", 32'(w_imem_req), 32'd0);
    step();
    check("wr_req", 32'(w_imem_req), 32'd1);
    check("wr_addr", w_imem_addr, 32'hFFFF_FFFC);
    step();
    w_rvalid = 1'b1;
    w_rdata  = 32'hCAFE_0013;
    #1;
    check("wr_rready", 32'(w_rready), 32'd1);
    step();
    w_rvalid = 1'b0;
    w_rdata  = 32'h0;
    #1;
    check("wr_valid", 32'(w_valid), 32'd1);
    check("wr_pc", w_pc, 32'hFFFF_FFFC);
    check("wr_pcplus4", w_pcplus4, 32'h0000_0000);
    check("wr_instr", w_instr, 32'hCAFE_0013);
    step();
    check("wr_next_req", 32'(w_imem_req), 32'd1);
    check("wr_next_addr", w_imem_addr, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
